// File: rtl/pop_graph_render.sv
`timescale 1ns/1ps
// Population-history overlay: counts live cells per sampled frame into a ring buffer and
// draws a scrolling, auto-scaled point graph with axes through a 3-cycle registered path.
module pop_graph_render #(
  parameter int unsigned GRAPH_X0    = 800,
  parameter int unsigned GRAPH_Y0    = 16,
  parameter int unsigned GRAPH_W     = 200,
  parameter int unsigned GRAPH_H     = 200,
  parameter int unsigned HISTORY_LEN = 25,
  parameter int unsigned SAMPLE_PIX  = 8,
  parameter int unsigned LOG_FRAMES  = 5,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned SCREEN_W    = 1024,
  parameter int unsigned SCREEN_H    = 768,
  parameter logic [11:0] PT_COLOR    = 12'hFFF,
  parameter logic [11:0] AXIS_COLOR  = 12'h888
) (
  input  logic             clk_130mhz,
  input  logic             rst_in,
  input  logic             pix_en_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             blank_in,
  input  logic             is_alive_in,
  input  logic             freeze_in,
  output logic [11:0]      pix_out,
  output logic             sample_valid_out,
  output logic [CNT_W-1:0] latest_count_out
);

  localparam int unsigned PTR_W  = (HISTORY_LEN > 1) ? $clog2(HISTORY_LEN) : 1;
  localparam int unsigned SUM_W  = PTR_W + 1;
  localparam int unsigned FILL_W = $clog2(HISTORY_LEN + 1);
  localparam int unsigned FC_W   = (LOG_FRAMES > 0) ? LOG_FRAMES : 1;
  localparam int unsigned SH_W   = $clog2(CNT_W + 1);
  localparam int unsigned HT_W   = (GRAPH_H > 1) ? $clog2(GRAPH_H) : 1;

  localparam logic [10:0] X0     = 11'(GRAPH_X0);
  localparam logic [10:0] X_END  = 11'(GRAPH_X0 + GRAPH_W);
  localparam logic [10:0] H_LAST = 11'(SCREEN_W - 1);
  localparam logic [9:0]  Y0     = 10'(GRAPH_Y0);
  localparam logic [9:0]  Y_AXIS = 10'(GRAPH_Y0 + GRAPH_H);
  localparam logic [9:0]  Y_BASE = 10'(GRAPH_Y0 + GRAPH_H - 1);
  localparam logic [9:0]  V_LAST = 10'(SCREEN_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  ring_q [HISTORY_LEN];

  logic              eof, cnt_phase, inc, commit;
  logic [CNT_W-1:0]  acc_q, acc_d, acc_inc, latest_q, latest_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] filled_q, filled_d;
  logic [SH_W-1:0]   scale_q, scale_d, s_need;
  logic              valid_q, valid_d;

  // Sample accumulation, commit and auto-scale bookkeeping
  always_comb begin
    eof       = pix_en_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    cnt_phase = (fc_q == '0);
    inc       = pix_en_in && !blank_in && is_alive_in && cnt_phase;
    acc_inc   = (inc && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;
    commit    = eof && !freeze_in && cnt_phase;

    s_need = SH_W'(CNT_W);
    for (int i = int'(CNT_W); i >= 0; i--) begin
      if (32'(acc_inc >> i) < GRAPH_H) s_need = SH_W'(i);
    end

    acc_d    = eof ? '0 : acc_inc;
    fc_d     = fc_q;
    wr_ptr_d = wr_ptr_q;
    filled_d = filled_q;
    latest_d = latest_q;
    scale_d  = scale_q;
    valid_d  = commit;
    if (eof && !freeze_in) fc_d = (LOG_FRAMES == 0) ? '0 : fc_q + FC_W'(1);
    if (commit) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(HISTORY_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      filled_d = (filled_q == FILL_W'(HISTORY_LEN)) ? filled_q : filled_q + FILL_W'(1);
      latest_d = acc_inc;
      if (s_need > scale_q) scale_d = s_need;
    end
  end

  always_ff @(posedge clk_130mhz or negedge rst_in) begin
    if (!rst_in) begin
      acc_q    <= '0;
      fc_q     <= '0;
      wr_ptr_q <= '0;
      filled_q <= '0;
      latest_q <= '0;
      scale_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      fc_q     <= fc_d;
      wr_ptr_q <= wr_ptr_d;
      filled_q <= filled_d;
      latest_q <= latest_d;
      scale_q  <= scale_d;
      valid_q  <= valid_d;
    end
  end

  // History storage is never cleared; filled_q hides stale entries after reset
  always_ff @(posedge clk_130mhz) begin
    if (commit) ring_q[wr_ptr_q] <= acc_inc;
  end

  logic              in_x_d;
  logic [10:0]       rel;
  logic [PTR_W-1:0]  col_d, idx_d;
  logic [SUM_W-1:0]  sum;

  // S1: graph column and ring index, oldest sample at the left once the ring is full
  always_comb begin
    in_x_d = (hcount_in >= X0) && (hcount_in < X_END);
    rel    = hcount_in - X0;
    col_d  = in_x_d ? PTR_W'(rel / 11'(SAMPLE_PIX)) : '0;
    sum    = SUM_W'(wr_ptr_q) + SUM_W'(col_d);
    if (filled_q < FILL_W'(HISTORY_LEN))     idx_d = col_d;
    else if (sum >= SUM_W'(HISTORY_LEN))     idx_d = PTR_W'(sum - SUM_W'(HISTORY_LEN));
    else                                     idx_d = PTR_W'(sum);
  end

  logic [10:0]      h1_q, h2_q;
  logic [9:0]       v1_q, v2_q;
  logic             b1_q, b2_q, in_x1_q, in_x2_q;
  logic [PTR_W-1:0] col1_q, col2_q, idx1_q;
  logic [CNT_W-1:0] sample, shifted;
  logic [HT_W-1:0]  ht_d, ht2_q;

  // S2: scaled and clipped point height
  always_comb begin
    sample  = ring_q[idx1_q];
    shifted = sample >> scale_q;
    ht_d    = (32'(shifted) > GRAPH_H - 1) ? HT_W'(GRAPH_H - 1) : HT_W'(shifted);
  end

  logic        x_axis, y_axis, pt;
  logic [11:0] pix_d, pix_q;

  // S3: blank > axis > point
  always_comb begin
    x_axis = (v2_q == Y_AXIS) && (h2_q >= X0) && (h2_q < X_END);
    y_axis = (h2_q == X0) && (v2_q >= Y0) && (v2_q <= Y_AXIS);
    pt     = in_x2_q && (FILL_W'(col2_q) < filled_q) && (v2_q == Y_BASE - 10'(ht2_q));
    pix_d  = '0;
    if (!b2_q) begin
      if (x_axis || y_axis) pix_d = AXIS_COLOR;
      else if (pt)          pix_d = PT_COLOR;
    end
  end

  always_ff @(posedge clk_130mhz or negedge rst_in) begin
    if (!rst_in) begin
      h1_q    <= '0;
      v1_q    <= '0;
      b1_q    <= 1'b1;
      in_x1_q <= 1'b0;
      col1_q  <= '0;
      idx1_q  <= '0;
      h2_q    <= '0;
      v2_q    <= '0;
      b2_q    <= 1'b1;
      in_x2_q <= 1'b0;
      col2_q  <= '0;
      ht2_q   <= '0;
      pix_q   <= '0;
    end else begin
      h1_q    <= hcount_in;
      v1_q    <= vcount_in;
      b1_q    <= blank_in;
      in_x1_q <= in_x_d;
      col1_q  <= col_d;
      idx1_q  <= idx_d;
      h2_q    <= h1_q;
      v2_q    <= v1_q;
      b2_q    <= b1_q;
      in_x2_q <= in_x1_q;
      col2_q  <= col1_q;
      ht2_q   <= ht_d;
      pix_q   <= pix_d;
    end
  end

  assign pix_out          = pix_q;
  assign sample_valid_out = valid_q;
  assign latest_count_out = latest_q;

endmodule

// File: tb/tb_pop_graph_render.sv
`timescale 1ns/1ps
// Bench for pop_graph_render: random frames against a queue-based history/scale model,
// with render probes compared to expected colours derived from the graph geometry.
module tb_pop_graph_render;

  localparam int CNT_W = 9;
  localparam int LOG_FRAMES = 1;
  localparam int HL = 25;
  localparam int X0 = 800;
  localparam int Y0 = 16;
  localparam int GW = 200;
  localparam int GH = 200;
  localparam int SP = 8;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam logic [11:0] PT = 12'hFFF;
  localparam logic [11:0] AX = 12'h888;

  logic             clk = 1'b0;
  logic             rst_in, pix_en_in, blank_in, is_alive_in, freeze_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic [11:0]      pix_out;
  logic             sample_valid_out;
  logic [CNT_W-1:0] latest_count_out;

  pop_graph_render #(.LOG_FRAMES(LOG_FRAMES), .CNT_W(CNT_W)) dut (
    .clk_130mhz(clk), .rst_in(rst_in), .pix_en_in(pix_en_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .blank_in(blank_in), .is_alive_in(is_alive_in),
    .freeze_in(freeze_in), .pix_out(pix_out), .sample_valid_out(sample_valid_out),
    .latest_count_out(latest_count_out)
  );

  always #5 clk = ~clk;

  int hist[$];
  int scale_m, fc_m, latest_m;
  int n_checks, n_pass, pulse_cnt;

  always @(negedge clk) if (sample_valid_out === 1'b1) pulse_cnt++;

  function automatic int shift_for(int c);
    int s = 0;
    while ((c >> s) >= GH) s++;
    return s;
  endfunction

  function automatic int row_of(int c);
    int h = c >> scale_m;
    if (h > GH - 1) h = GH - 1;
    return Y0 + GH - 1 - h;
  endfunction

  function automatic logic [11:0] exp_pix(int h, int v, bit b);
    int col;
    if (b) return 12'h000;
    if ((v == Y0 + GH && h >= X0 && h < X0 + GW) || (h == X0 && v >= Y0 && v <= Y0 + GH))
      return AX;
    if (h >= X0 && h < X0 + GW) begin
      col = (h - X0) / SP;
      if (col < hist.size() && v == row_of(hist[col])) return PT;
    end
    return 12'h000;
  endfunction

  task automatic model_reset();
    hist.delete();
    scale_m = 0;
    fc_m = 0;
    latest_m = 0;
  endtask

  task automatic do_reset();
    pix_en_in = 1'b0;
    rst_in = 1'b0;
    @(posedge clk); #1;
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic drive_pix(int h, int v, bit b, bit a);
    pix_en_in = 1'b1; hcount_in = 11'(h); vcount_in = 10'(v);
    blank_in = b; is_alive_in = a;
    @(posedge clk); #1;
    pix_en_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic probe(int h, int v, bit b, output logic [11:0] obs);
    pix_en_in = 1'b1; is_alive_in = 1'b0; hcount_in = 11'(h); vcount_in = 10'(v);
    blank_in = b;
    repeat (3) @(posedge clk);
    #1 obs = pix_out;
  endtask

  // Packed result: {valid after EOF, valid one cycle later, pulses in frame, latest count}
  task automatic run_frame(int n_live, int n_blank, bit frz, bit eof_alive,
                           output logic [25:0] obs, output logic [25:0] expv);
    int p0, counted;
    logic va, vb;
    logic [15:0] lat;
    bit cm;
    p0 = pulse_cnt;
    freeze_in = frz;
    for (int i = 0; i < n_live; i++)
      drive_pix($urandom_range(0, 1023), $urandom_range(0, 766), 1'b0, 1'b1);
    for (int i = 0; i < n_blank; i++)
      drive_pix($urandom_range(0, 1023), $urandom_range(0, 766), 1'b1, 1'b1);
    pix_en_in = 1'b1; hcount_in = 11'd1023; vcount_in = 10'd767;
    blank_in = 1'b0; is_alive_in = eof_alive;
    @(posedge clk); #1;
    va = sample_valid_out;
    lat = 16'(latest_count_out);
    pix_en_in = 1'b0; is_alive_in = 1'b0;
    @(posedge clk); #1;
    vb = sample_valid_out;
    freeze_in = 1'b0;
    obs = {va, vb, 8'(pulse_cnt - p0), lat};
    counted = (fc_m == 0) ? ((n_live + int'(eof_alive) > MAXC) ? MAXC : n_live + int'(eof_alive)) : 0;
    cm = !frz && fc_m == 0;
    if (!frz) begin
      if (fc_m == 0) begin
        hist.push_back(counted);
        if (hist.size() > HL) void'(hist.pop_front());
        latest_m = counted;
        if (shift_for(counted) > scale_m) scale_m = shift_for(counted);
      end
      fc_m = (fc_m + 1) % (1 << LOG_FRAMES);
    end
    expv = {cm, 1'b0, 8'(cm), 16'(latest_m)};
  endtask

  task automatic align_phase();
    logic [25:0] o, e;
    while (fc_m != 0) run_frame(0, 0, 1'b0, 1'b0, o, e);
  endtask

  task automatic test_render_snapshot(string tag);
    logic [11:0] obs, e;
    int h, v;
    bit b;
    for (int c = 0; c < HL; c++) begin
      h = X0 + c * SP + $urandom_range(1, SP - 1);
      v = (c < hist.size()) ? row_of(hist[c]) : $urandom_range(Y0, Y0 + GH - 1);
      probe(h, v, 1'b0, obs);
      e = exp_pix(h, v, 1'b0);
      if (obs !== e) $display("FAIL %s col%0d (%0d,%0d): got %h expected %h", tag, c, h, v, obs, e);
      else n_pass++;
      n_checks++;
    end
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: begin h = X0; v = $urandom_range(Y0, Y0 + GH); end
        1: begin h = $urandom_range(X0, X0 + GW - 1); v = Y0 + GH; end
        2: begin h = $urandom_range(0, 1023); v = $urandom_range(0, 766); end
        default: begin h = $urandom_range(X0, X0 + GW - 1); v = $urandom_range(Y0, Y0 + GH); end
      endcase
      b = (k == 4);
      probe(h, v, b, obs);
      e = exp_pix(h, v, b);
      if (obs !== e) $display("FAIL %s misc%0d (%0d,%0d,b%0d): got %h expected %h", tag, k, h, v, b, obs, e);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_reset();
    #2;
    if ({pix_out, sample_valid_out, latest_count_out} !== '0)
      $display("FAIL reset_no_edge: got %h/%b/%0d expected 0/0/0", pix_out, sample_valid_out, latest_count_out);
    else n_pass++;
    n_checks++;
    repeat (2) @(posedge clk);
    #1;
    if ({pix_out, sample_valid_out, latest_count_out} !== '0)
      $display("FAIL reset_held: got %h/%b/%0d expected 0/0/0", pix_out, sample_valid_out, latest_count_out);
    else n_pass++;
    n_checks++;
    rst_in = 1'b1;
    model_reset();
    test_render_snapshot("after_reset");
  endtask

  task automatic test_single_commit();
    logic [25:0] o, e;
    logic [11:0] obs;
    int ph[4] = '{803, 807, 808, 805};
    int pv[4] = '{175, 175, 175, 176};
    logic [11:0] pe[4] = '{PT, PT, 12'h000, 12'h000};
    run_frame(40, 10, 1'b0, 1'b0, o, e);
    if (o !== e) $display("FAIL single_frame: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    if (latest_count_out !== 9'd40) $display("FAIL latest40: got %0d expected 40", latest_count_out);
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      probe(ph[i], pv[i], 1'b0, obs);
      if (obs !== pe[i]) $display("FAIL point40 (%0d,%0d): got %h expected %h", ph[i], pv[i], obs, pe[i]);
      else n_pass++;
      n_checks++;
    end
    run_frame(25, 0, 1'b0, 1'b1, o, e);
    if (o !== e) $display("FAIL skipped_frame: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    test_render_snapshot("single");
  endtask

  task automatic test_wrap();
    logic [25:0] o, e;
    logic [11:0] obs;
    int ph[3] = '{804, 999, 801};
    int pv[3] = '{209, 185, 210};
    logic [11:0] pe[3] = '{PT, PT, 12'h000};
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      align_phase();
      run_frame(k - 1, $urandom_range(0, 3), 1'b0, 1'b1, o, e);
      if (o !== e) $display("FAIL wrap_commit%0d: got %h expected %h", k, o, e);
      else n_pass++;
      n_checks++;
    end
    for (int i = 0; i < 3; i++) begin
      probe(ph[i], pv[i], 1'b0, obs);
      if (obs !== pe[i]) $display("FAIL wrap_edge (%0d,%0d): got %h expected %h", ph[i], pv[i], obs, pe[i]);
      else n_pass++;
      n_checks++;
    end
    test_render_snapshot("wrap");
  endtask

  task automatic test_autoscale();
    logic [25:0] o, e;
    logic [11:0] obs;
    int ph[3] = '{995, 990, 995};
    int pv[3] = '{213, 103, 103};
    logic [11:0] pe[3] = '{PT, PT, 12'h000};
    align_phase();
    run_frame(449, 2, 1'b0, 1'b1, o, e);
    if (o !== e) $display("FAIL commit450: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    probe(995, 103, 1'b0, obs);
    if (obs !== PT) $display("FAIL scaled450: got %h expected %h", obs, PT);
    else n_pass++;
    n_checks++;
    align_phase();
    run_frame(10, 0, 1'b0, 1'b0, o, e);
    if (o !== e) $display("FAIL commit10: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      probe(ph[i], pv[i], 1'b0, obs);
      if (obs !== pe[i]) $display("FAIL scale_kept (%0d,%0d): got %h expected %h", ph[i], pv[i], obs, pe[i]);
      else n_pass++;
      n_checks++;
    end
    test_render_snapshot("autoscale");
  endtask

  task automatic test_freeze();
    logic [25:0] o, e;
    align_phase();
    for (int f = 0; f < 3; f++) begin
      run_frame($urandom_range(5, 30), 2, 1'b1, 1'b1, o, e);
      if (o !== e) $display("FAIL frozen%0d: got %h expected %h", f, o, e);
      else n_pass++;
      n_checks++;
    end
    test_render_snapshot("frozen");
    run_frame(12, 0, 1'b0, 1'b0, o, e);
    if (o !== e) $display("FAIL unfreeze: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    if (latest_count_out !== 9'd12) $display("FAIL unfreeze_latest: got %0d expected 12", latest_count_out);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_saturate();
    logic [25:0] o, e;
    align_phase();
    run_frame(520, 0, 1'b0, 1'b1, o, e);
    if (o !== e) $display("FAIL saturate: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    if (latest_count_out !== 9'd511) $display("FAIL sat_latest: got %0d expected 511", latest_count_out);
    else n_pass++;
    n_checks++;
    test_render_snapshot("saturate");
  endtask

  task automatic test_reset_midframe();
    logic [25:0] o, e;
    logic [11:0] obs;
    align_phase();
    for (int i = 0; i < 30; i++)
      drive_pix($urandom_range(0, 1023), $urandom_range(0, 766), 1'b0, 1'b1);
    probe(X0, 100, 1'b0, obs);
    if (obs !== AX) $display("FAIL pre_reset_axis: got %h expected %h", obs, AX);
    else n_pass++;
    n_checks++;
    rst_in = 1'b0;
    #1;
    if ({pix_out, sample_valid_out, latest_count_out} !== '0)
      $display("FAIL async_reset: got %h/%b/%0d expected 0/0/0", pix_out, sample_valid_out, latest_count_out);
    else n_pass++;
    n_checks++;
    @(posedge clk); #1;
    rst_in = 1'b1;
    model_reset();
    test_render_snapshot("post_reset");
    run_frame(7, 3, 1'b0, 1'b0, o, e);
    if (o !== e) $display("FAIL post_reset_commit: got %h expected %h", o, e);
    else n_pass++;
    n_checks++;
    if (latest_count_out !== 9'd7) $display("FAIL post_reset_latest: got %0d expected 7", latest_count_out);
    else n_pass++;
    n_checks++;
    test_render_snapshot("post_reset_commit");
  endtask

  task automatic test_random();
    logic [25:0] o, e;
    for (int it = 0; it < 24; it++) begin
      run_frame($urandom_range(0, 300), $urandom_range(0, 10), ($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 1)), o, e);
      if (o !== e) $display("FAIL random_frame%0d: got %h expected %h", it, o, e);
      else n_pass++;
      n_checks++;
      if (it % 6 == 5) test_render_snapshot("random");
    end
  endtask

  initial begin
    rst_in = 1'b0; pix_en_in = 1'b0; blank_in = 1'b0; is_alive_in = 1'b0;
    freeze_in = 1'b0; hcount_in = '0; vcount_in = '0;
    n_checks = 0; n_pass = 0; pulse_cnt = 0;
    model_reset();
    test_reset();
    test_single_commit();
    test_wrap();
    test_autoscale();
    test_freeze();
    test_saturate();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
